// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues reads to a 1-cycle-latency
// instruction memory and buffers returned words in a small valid/ready FIFO.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2,
  parameter logic [31:0] NOP_INS    = 32'hE1A0_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic [31:0] ins,
  output logic [31:0] ins_pc,
  output logic        ins_valid,
  input  logic        ins_ready,
  output logic [31:0] pc_plus8
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic {BOOT, RUN} state_t;

  state_t           state_reg, state_next;
  logic [31:0]      pc_reg, pc_next;
  logic [31:0]      req_pc_reg, req_pc_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic             resp_pending_reg, resp_pending_next;
  logic             kill_reg, kill_next;

  logic [31:0] data_mem [FIFO_DEPTH];
  logic [31:0] pc_mem   [FIFO_DEPTH];

  logic       full, empty, pop, push, issue;
  logic [4:0] occupancy;

  assign full  = (count_reg == FULL_CNT);
  assign empty = (count_reg == '0);
  assign pop   = !empty && ins_ready;
  // A response landing in a redirect cycle belongs to the old stream.
  assign push  = resp_pending_reg && !kill_reg && !br_taken;

  // Words already held plus the one in flight, minus the one leaving now.
  assign occupancy = 5'(count_reg) + 5'(resp_pending_reg) - 5'(pop);

  always_comb begin
    state_next = state_reg;
    issue      = 1'b0;
    case (state_reg)
      BOOT: state_next = RUN;
      RUN:  issue = rst && !br_taken && (occupancy < 5'(FIFO_DEPTH));
      default: state_next = BOOT;
    endcase
  end

  always_comb begin
    pc_next           = pc_reg;
    req_pc_next       = req_pc_reg;
    count_next        = count_reg;
    rd_ptr_next       = rd_ptr_reg;
    wr_ptr_next       = wr_ptr_reg;
    resp_pending_next = issue;
    kill_next         = 1'b0;

    if (issue) begin
      pc_next     = pc_reg + 32'd4;
      req_pc_next = pc_reg;
    end

    if (br_taken) begin
      pc_next     = br_target & ~32'h3;
      count_next  = '0;
      rd_ptr_next = '0;
      wr_ptr_next = '0;
      kill_next   = resp_pending_next;
    end else begin
      if (pop) begin
        rd_ptr_next = (rd_ptr_reg == LAST_PTR) ? '0 : rd_ptr_reg + 1'b1;
      end
      if (push) begin
        wr_ptr_next = (wr_ptr_reg == LAST_PTR) ? '0 : wr_ptr_reg + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_next = count_reg + 1'b1;
        2'b01:   count_next = count_reg - 1'b1;
        default: count_next = count_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg        <= BOOT;
      pc_reg           <= RESET_PC;
      req_pc_reg       <= RESET_PC;
      count_reg        <= '0;
      rd_ptr_reg       <= '0;
      wr_ptr_reg       <= '0;
      resp_pending_reg <= 1'b0;
      kill_reg         <= 1'b0;
    end else begin
      state_reg        <= state_next;
      pc_reg           <= pc_next;
      req_pc_reg       <= req_pc_next;
      count_reg        <= count_next;
      rd_ptr_reg       <= rd_ptr_next;
      wr_ptr_reg       <= wr_ptr_next;
      resp_pending_reg <= resp_pending_next;
      kill_reg         <= kill_next;
    end
  end

  // Storage needs no reset: entries are only visible through count_reg.
  always_ff @(posedge clk) begin
    if (rst && push) begin
      data_mem[wr_ptr_reg] <= imem_rdata;
      pc_mem[wr_ptr_reg]   <= req_pc_reg;
    end
  end

  assign imem_req  = issue;
  assign imem_addr = pc_reg;
  assign ins_valid = !empty;
  assign ins       = empty ? NOP_INS : data_mem[rd_ptr_reg];
  assign ins_pc    = empty ? 32'd0   : pc_mem[rd_ptr_reg];
  assign pc_plus8  = ins_pc + 32'd8;

  no_overflow_a: assert property (@(posedge clk) disable iff (!rst) !(push && full));

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: queue-based fetch model checked every cycle, plus
// directed scenarios with literal expectations (streaming, stall, redirects, wrap, reset).
module tb_fetch_unit;

  localparam int          DEPTH = 2;
  localparam logic [31:0] NOP   = 32'hE1A0_0000;
  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        br_taken = 1'b0;
  logic [31:0] br_target = 32'd0;
  logic        ins_ready = 1'b0;
  logic        imem_req, ins_valid;
  logic [31:0] imem_addr, ins, ins_pc, pc_plus8;
  logic [31:0] imem_rdata = 32'd0;

  logic        b_req, b_valid;
  logic [31:0] b_addr, b_ins, b_ins_pc, b_pc8;
  logic [31:0] b_rdata = 32'd0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0), .FIFO_DEPTH(DEPTH), .NOP_INS(NOP)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .br_taken(br_taken), .br_target(br_target),
    .ins(ins), .ins_pc(ins_pc), .ins_valid(ins_valid), .ins_ready(ins_ready),
    .pc_plus8(pc_plus8)
  );

  fetch_unit #(.RESET_PC(WRAP_PC), .FIFO_DEPTH(DEPTH), .NOP_INS(NOP)) dut_wrap (
    .clk(clk), .rst(rst), .imem_req(b_req), .imem_addr(b_addr),
    .imem_rdata(b_rdata), .br_taken(1'b0), .br_target(32'h0),
    .ins(b_ins), .ins_pc(b_ins_pc), .ins_valid(b_valid), .ins_ready(1'b1),
    .pc_plus8(b_pc8)
  );

  // Instruction memory: word at address A holds A>>2, one cycle of latency.
  always @(posedge clk) begin
    imem_rdata <= imem_addr >> 2;
    b_rdata    <= b_addr >> 2;
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp, input bit quiet);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end else if (!quiet) begin
      $display("[TB] ok %s = %h", name, act);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_buf[$];
  logic [31:0] m_pc;
  logic [31:0] m_fly_addr;
  bit          m_fly, m_run, m_init;
  logic [31:0] seen[$];
  logic [31:0] b_seen[$];
  logic [31:0] b_seen_p8[$];

  function automatic bit m_req();
    int occ;
    if (!rst || !m_run || br_taken) return 1'b0;
    occ = m_buf.size() + int'(m_fly) - ((m_buf.size() > 0 && ins_ready) ? 1 : 0);
    return occ < DEPTH;
  endfunction

  task automatic model_step();
    bit req, pop;
    if (!rst) begin
      m_buf.delete();
      m_fly  = 1'b0;
      m_pc   = 32'h0;
      m_run  = 1'b0;
      m_init = 1'b1;
    end else if (m_init) begin
      req = m_req();
      pop = (m_buf.size() > 0) && ins_ready;
      if (br_taken) begin
        m_buf.delete();
        m_fly = 1'b0;
        m_pc  = br_target & ~32'h3;
      end else begin
        if (pop) void'(m_buf.pop_front());
        if (m_fly) begin
          if (m_buf.size() >= DEPTH) check("model_overflow", 32'(m_buf.size()), 32'(DEPTH - 1), 1'b1);
          m_buf.push_back(m_fly_addr);
        end
        m_fly = req;
        if (req) begin
          m_fly_addr = m_pc;
          m_pc = m_pc + 32'd4;
        end
      end
      m_run = 1'b1;
    end
  endtask

  task automatic compare_step();
    logic [31:0] e_pc;
    bit e_valid, e_req;
    if (b_valid && b_seen.size() < 3) begin
      b_seen.push_back(b_ins_pc);
      b_seen_p8.push_back(b_pc8);
    end
    if (ins_valid) seen.push_back(ins_pc);
    if (!m_init) return;
    e_valid = m_buf.size() > 0;
    e_pc    = e_valid ? m_buf[0] : 32'h0;
    e_req   = m_req();
    check("cyc_valid", 32'(ins_valid), 32'(e_valid), 1'b1);
    check("cyc_ins", ins, e_valid ? (e_pc >> 2) : NOP, 1'b1);
    check("cyc_ins_pc", ins_pc, e_pc, 1'b1);
    check("cyc_pc_plus8", pc_plus8, e_pc + 32'd8, 1'b1);
    check("cyc_imem_req", 32'(imem_req), 32'(e_req), 1'b1);
    if (e_req) check("cyc_imem_addr", imem_addr, m_pc, 1'b1);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare_step();
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    bit hit200;
    rst = 1'b0;
    ins_ready = 1'b1;
    tick(2);
    check("reset_valid", 32'(ins_valid), 32'd0, 1'b0);
    check("reset_ins", ins, 32'hE1A0_0000, 1'b0);
    check("reset_pc_plus8", pc_plus8, 32'd8, 1'b0);
    check("reset_req", 32'(imem_req), 32'd0, 1'b0);

    // Streaming from reset release
    rst = 1'b1;
    check("boot_req", 32'(imem_req), 32'd0, 1'b0);
    tick(1);
    check("first_req", 32'(imem_req), 32'd1, 1'b0);
    check("first_addr", imem_addr, 32'd0, 1'b0);
    tick(1);
    check("pending_valid", 32'(ins_valid), 32'd0, 1'b0);
    tick(1);
    check("first_valid", 32'(ins_valid), 32'd1, 1'b0);
    check("first_ins", ins, 32'd0, 1'b0);
    check("first_ins_pc", ins_pc, 32'd0, 1'b0);
    tick(1);
    check("stream_pc4", ins_pc, 32'd4, 1'b0);
    check("stream_p8_4", pc_plus8, 32'd12, 1'b0);
    tick(1);
    check("stream_pc8", ins_pc, 32'd8, 1'b0);
    tick(1);
    check("stream_pc12", ins_pc, 32'd12, 1'b0);

    // Stall: 12 held at the head, 16 arrives, then nothing more is requested
    ins_ready = 1'b0;
    tick(5);
    check("stall_valid", 32'(ins_valid), 32'd1, 1'b0);
    check("stall_head", ins_pc, 32'd12, 1'b0);
    check("stall_req", 32'(imem_req), 32'd0, 1'b0);
    ins_ready = 1'b1;
    check("release_head", ins_pc, 32'd12, 1'b0);
    tick(1);
    check("release_next", ins_pc, 32'd16, 1'b0);
    tick(1);
    check("release_third", ins_pc, 32'd20, 1'b0);
    check("release_ins", ins, 32'd5, 1'b0);

    // Single redirect to an unaligned target
    br_taken = 1'b1;
    br_target = 32'h0000_0103;
    tick(1);
    br_taken = 1'b0;
    seen.delete();
    check("redir_flushed", 32'(ins_valid), 32'd0, 1'b0);
    tick(6);
    check("redir_count", 32'(seen.size() >= 2), 32'd1, 1'b0);
    if (seen.size() >= 2) begin
      check("redir_first", seen[0], 32'h100, 1'b0);
      check("redir_second", seen[1], 32'h104, 1'b0);
    end

    // Back-to-back redirects: the second wins
    br_taken = 1'b1;
    br_target = 32'h200;
    tick(1);
    br_target = 32'h300;
    tick(1);
    br_taken = 1'b0;
    seen.delete();
    tick(6);
    hit200 = 1'b0;
    foreach (seen[i]) if (seen[i] == 32'h200) hit200 = 1'b1;
    check("b2b_count", 32'(seen.size() >= 1), 32'd1, 1'b0);
    if (seen.size() >= 1) check("b2b_first", seen[0], 32'h300, 1'b0);
    check("b2b_no_200", 32'(hit200), 32'd0, 1'b0);

    // PC wrap on the second instance, captured since the first release
    check("wrap_count", 32'(b_seen.size()), 32'd3, 1'b0);
    if (b_seen.size() == 3) begin
      check("wrap_pc0", b_seen[0], 32'hFFFF_FFF8, 1'b0);
      check("wrap_pc1", b_seen[1], 32'hFFFF_FFFC, 1'b0);
      check("wrap_pc2", b_seen[2], 32'h0000_0000, 1'b0);
      check("wrap_p8_0", b_seen_p8[0], 32'h0000_0000, 1'b0);
    end

    // Reset with a full FIFO
    ins_ready = 1'b0;
    tick(3);
    check("pre_reset_full", 32'(ins_valid), 32'd1, 1'b0);
    rst = 1'b0;
    tick(1);
    check("midreset_valid", 32'(ins_valid), 32'd0, 1'b0);
    check("midreset_ins", ins, NOP, 1'b0);
    check("midreset_ins_pc", ins_pc, 32'd0, 1'b0);
    rst = 1'b1;
    ins_ready = 1'b1;
    seen.delete();
    tick(8);
    check("restart_count", 32'(seen.size() >= 2), 32'd1, 1'b0);
    if (seen.size() >= 2) begin
      check("restart_first", seen[0], 32'd0, 1'b0);
      check("restart_second", seen[1], 32'd4, 1'b0);
    end

    tick(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
